// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch front end: bubble instruction,
// base opcodes shared with the decoder, and the fetch FSM state type.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } fetch_state_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit
// (master) and instruction memory (slave).
interface instr_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/instr_fetch_unit_skid.sv
// One-entry holding register for an instruction (and its PC) that
// returned from memory while the pipeline was stalled.
module fetch_skid_buffer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        full,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    // Capture on load, empty on drain; clear and reset both discard the entry.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            full      <= 1'b0;
            out_instr <= 32'h0;
            out_pc    <= 32'h0;
        end else if (load) begin
            full      <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (drain) begin
            full      <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues one outstanding instruction memory
// request at a time, and feeds the IF/ID pipeline register.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = instr_fetch_unit_pkg::NOP_INSTR
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    instr_fetch_unit_if.master        imem,
    input  logic                      stall_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    output logic                      if_id_valid_o,
    output logic [31:0]               if_id_instr_o,
    output logic [31:0]               if_id_pc_o,
    output logic [31:0]               if_id_pc4_o
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] discard_addr;
    logic [31:0] redirect_target;

    logic        fetch_take;
    logic        skid_load;
    logic        skid_drain;
    logic        skid_full;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    assign redirect_target = align_pc(redirect_pc_i);

    // An ack is usable only in S_FETCH and only if no redirect kills it.
    assign fetch_take = (state == S_FETCH) && imem.ack && !redirect_i;
    assign skid_load  = fetch_take && stall_i;
    assign skid_drain = skid_full && !stall_i && !redirect_i;

    fetch_skid_buffer u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (redirect_i),
        .in_instr  (imem.rdata),
        .in_pc     (pc),
        .full      (skid_full),
        .out_instr (skid_instr),
        .out_pc    (skid_pc)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_i) begin
                    state_next = imem.ack ? S_FETCH : S_DISCARD;
                end else if (imem.ack && stall_i) begin
                    state_next = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (imem.ack) begin
                    state_next = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect_i || !stall_i) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs: the stale address stays on the bus while a killed request drains.
    always_comb begin
        imem.req  = (state == S_FETCH) || (state == S_DISCARD);
        imem.addr = (state == S_DISCARD) ? discard_addr : pc;
    end

    // Next PC: redirect wins, otherwise advance on each accepted fetch.
    always_comb begin
        pc_next = pc;
        case (state)
            S_FETCH: begin
                if (redirect_i) begin
                    pc_next = redirect_target;
                end else if (imem.ack) begin
                    pc_next = pc + 32'd4;
                end
            end
            S_DISCARD, S_HOLD: begin
                if (redirect_i) begin
                    pc_next = redirect_target;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    // PC register and the address of a request being discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc           <= RESET_PC;
            discard_addr <= RESET_PC;
        end else begin
            pc <= pc_next;
            if ((state == S_FETCH) && redirect_i && !imem.ack) begin
                discard_addr <= pc;
            end
        end
    end

    // IF/ID register: flush, then stall, then skid entry, then fresh data, else bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP_INSTR;
            if_id_pc_o    <= 32'h0;
            if_id_pc4_o   <= 32'd4;
        end else if (redirect_i) begin
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP_INSTR;
        end else if (stall_i) begin
            if_id_valid_o <= if_id_valid_o;
        end else if (skid_full) begin
            if_id_valid_o <= 1'b1;
            if_id_instr_o <= skid_instr;
            if_id_pc_o    <= skid_pc;
            if_id_pc4_o   <= skid_pc + 32'd4;
        end else if (fetch_take) begin
            if_id_valid_o <= 1'b1;
            if_id_instr_o <= imem.rdata;
            if_id_pc_o    <= pc;
            if_id_pc4_o   <= pc + 32'd4;
        end else begin
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP_INSTR;
        end
    end

    // Memory must not acknowledge without a request (idle cycles after reset excepted).
    ack_needs_req: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (imem.ack && (state != S_IDLE)) |-> imem.req
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit: one vector per clock
// cycle with the inputs to drive and the outputs expected in that cycle.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem          (imem_bus),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .if_id_valid_o (if_id_valid),
        .if_id_instr_o (if_id_instr),
        .if_id_pc_o    (if_id_pc),
        .if_id_pc4_o   (if_id_pc4)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst_v, input logic ack_v, input logic [31:0] rdata_v,
        input logic stall_v, input logic redir_v, input logic [31:0] rpc_v,
        input logic e_req_v, input logic chk_v, input logic [31:0] e_addr_v,
        input logic e_valid_v, input logic [31:0] e_instr_v, input logic [31:0] e_pc_v);
        vec_t v;
        v.rst = rst_v;       v.ack = ack_v;       v.rdata = rdata_v;
        v.stall = stall_v;   v.redir = redir_v;   v.rpc = rpc_v;
        v.e_req = e_req_v;   v.chk_addr = chk_v;  v.e_addr = e_addr_v;
        v.e_valid = e_valid_v; v.e_instr = e_instr_v; v.e_pc = e_pc_v;
        return v;
    endfunction

    task automatic compare(input string what, input int idx,
                           input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s vec %0d: got %h expected %h", what, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        imem_bus.ack   = v.ack;
        imem_bus.rdata = v.rdata;
        stall          = v.stall;
        redir          = v.redir;
        redir_pc       = v.rpc;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        #1;
        compare("req", idx, {31'h0, imem_bus.req}, {31'h0, v.e_req});
        if (v.chk_addr) compare("addr", idx, imem_bus.addr, v.e_addr);
        compare("valid", idx, {31'h0, if_id_valid}, {31'h0, v.e_valid});
        compare("instr", idx, if_id_instr, v.e_instr);
        compare("pc", idx, if_id_pc, v.e_pc);
        compare("pc4", idx, if_id_pc4, v.e_pc + 32'd4);
    endtask

    initial begin
        vec_t v;

        rst = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        imem_bus.ack = 1'b0; imem_bus.rdata = 32'h0;

        //                rst ack rdata         stl rd rpc            req chk addr          vld instr         pc
        // Reset release with ack tied high: streaming fetch.
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,         0, 0, 32'h0,         0, NOP,          32'h0));
        vecs.push_back(mk(0, 1, 32'hC0DE0000, 0, 0, 32'h0,         1, 1, 32'h0,         0, NOP,          32'h0));
        vecs.push_back(mk(0, 1, 32'hC0DE0004, 0, 0, 32'h0,         1, 1, 32'h4,         1, 32'hC0DE0000, 32'h0));
        vecs.push_back(mk(0, 1, 32'hC0DE0008, 0, 0, 32'h0,         1, 1, 32'h8,         1, 32'hC0DE0004, 32'h4));
        vecs.push_back(mk(0, 1, 32'hC0DE000C, 0, 0, 32'h0,         1, 1, 32'hC,         1, 32'hC0DE0008, 32'h8));
        // Three-cycle ack latency at 0x10 and 0x14.
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h10,        1, 32'hC0DE000C, 32'hC));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h10,        0, NOP,          32'hC));
        vecs.push_back(mk(0, 1, 32'hC0DE0010, 0, 0, 32'h0,         1, 1, 32'h10,        0, NOP,          32'hC));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h14,        1, 32'hC0DE0010, 32'h10));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h14,        0, NOP,          32'h10));
        vecs.push_back(mk(0, 1, 32'hC0DE0014, 0, 0, 32'h0,         1, 1, 32'h14,        0, NOP,          32'h10));
        vecs.push_back(mk(0, 1, 32'hC0DE0018, 0, 0, 32'h0,         1, 1, 32'h18,        1, 32'hC0DE0014, 32'h14));
        vecs.push_back(mk(0, 1, 32'hC0DE001C, 0, 0, 32'h0,         1, 1, 32'h1C,        1, 32'hC0DE0018, 32'h18));
        // Four-cycle stall while 0x20 returns: skid buffer then drain.
        vecs.push_back(mk(0, 1, 32'hC0DE0020, 1, 0, 32'h0,         1, 1, 32'h20,        1, 32'hC0DE001C, 32'h1C));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC0DE001C, 32'h1C));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC0DE001C, 32'h1C));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC0DE001C, 32'h1C));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC0DE001C, 32'h1C));
        vecs.push_back(mk(0, 1, 32'hC0DE0024, 0, 0, 32'h0,         1, 1, 32'h24,        1, 32'hC0DE0020, 32'h20));
        // Redirect with same-cycle ack to 0x40: data dropped, stays fetching.
        vecs.push_back(mk(0, 1, 32'hC0DE0028, 0, 1, 32'h40,        1, 1, 32'h28,        1, 32'hC0DE0024, 32'h24));
        // Redirect to 0x100 while slow 0x40 request is outstanding.
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h40,        0, NOP,          32'h24));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h100,       1, 1, 32'h40,        0, NOP,          32'h24));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h40,        0, NOP,          32'h24));
        vecs.push_back(mk(0, 1, 32'hC0DE0040, 0, 0, 32'h0,         1, 1, 32'h40,        0, NOP,          32'h24));
        vecs.push_back(mk(0, 1, 32'hC0DE0100, 0, 0, 32'h0,         1, 1, 32'h100,       0, NOP,          32'h24));
        vecs.push_back(mk(0, 1, 32'hC0DE0104, 0, 0, 32'h0,         1, 1, 32'h104,       1, 32'hC0DE0100, 32'h100));
        // Stall into S_HOLD, then redirect+stall together to 0x103.
        vecs.push_back(mk(0, 1, 32'hC0DE0108, 1, 0, 32'h0,         1, 1, 32'h108,       1, 32'hC0DE0104, 32'h104));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC0DE0104, 32'h104));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h103,       0, 0, 32'h0,         1, 32'hC0DE0104, 32'h104));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h100,       0, NOP,          32'h104));
        vecs.push_back(mk(0, 1, 32'hC0DE0100, 0, 0, 32'h0,         1, 1, 32'h100,       0, NOP,          32'h104));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h104,       1, 32'hC0DE0100, 32'h100));
        // Reset while waiting in S_DISCARD; late ack lands during reset.
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h200,       1, 1, 32'h104,       0, NOP,          32'h100));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h104,       0, NOP,          32'h100));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h104,       0, NOP,          32'h100));
        vecs.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0, 32'h0,         0, 1, 32'h0,         0, NOP,          32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 1, 32'h0,         0, NOP,          32'h0));
        vecs.push_back(mk(0, 1, 32'hC0DE0000, 0, 0, 32'h0,         1, 1, 32'h0,         0, NOP,          32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h4,         1, 32'hC0DE0000, 32'h0));

        $display("[TB] starting, %0d table vectors", vecs.size());

        // Hand-written: hold reset for two edges, then check the reset state.
        repeat (2) @(posedge clk);
        v = mk(1, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0, 0, NOP, 32'h0);
        applyStimulus(v);
        checkOutput(v, -1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Hand-written: PC wraps from 0xFFFFFFFC to 0, and pc4 wraps with it.
        v = mk(0, 1, 32'h12345678, 0, 1, 32'hFFFFFFFE, 1, 1, 32'h4, 0, NOP, 32'h0);
        applyStimulus(v);
        checkOutput(v, 100);
        v = mk(0, 1, 32'h00A00093, 0, 0, 32'h0, 1, 1, 32'hFFFFFFFC, 0, NOP, 32'h0);
        applyStimulus(v);
        checkOutput(v, 101);
        v = mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0, 1, 32'h00A00093, 32'hFFFFFFFC);
        applyStimulus(v);
        checkOutput(v, 102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
